// File: rtl/rgb_sequence_monitor_if.sv
// Colour-bus interface for rgb_sequence_monitor: BGR input from the cycler side,
// decoded index / lock / error status back from the monitor.
interface rgb_sequence_monitor_if;
  logic [2:0] BGR_in;
  logic [2:0] color_idx;
  logic       idx_valid;
  logic       locked;
  logic       seq_error;
  logic [7:0] err_count;
  logic       stall;

  modport master (
    output BGR_in,
    input  color_idx, idx_valid, locked, seq_error, err_count, stall
  );

  modport slave (
    input  BGR_in,
    output color_idx, idx_valid, locked, seq_error, err_count, stall
  );
endinterface

// File: rtl/rgb_sequence_monitor.sv
// Receive-side checker for the cycler's BGR bus: sync, stability filter, decode, order tracking.
// Optional idle timeout / stall pulse enabled by defining RGB_MON_TIMEOUT_EN.
module rgb_sequence_monitor #(
  parameter int STABLE_CYCLES  = 16,
  parameter int LOCK_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  rgb_sequence_monitor_if.slave  bus
);

  localparam int FW = $clog2(STABLE_CYCLES + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {S_HUNT, S_CHECK, S_LOCKED} state_t;

  // ---------------- input path ----------------
  logic [2:0]    r_sync1, r_sync2, r_prev;
  logic [FW-1:0] r_filt_cnt;
  logic          r_acc_stb;
  logic [2:0]    r_acc_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_filt_cnt <= '0;
      r_acc_stb  <= 1'b0;
      r_acc_val  <= '0;
    end else begin
      r_sync1 <= bus.BGR_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_sync2 != r_prev)
        r_filt_cnt <= FW'(1);
      else if (r_filt_cnt != FW'(STABLE_CYCLES))
        r_filt_cnt <= r_filt_cnt + FW'(1);
      // acceptance is registered so the decoder sees a clean strobe/value pair
      r_acc_stb <= (r_filt_cnt == FW'(STABLE_CYCLES));
      r_acc_val <= r_prev;
    end
  end

  // ---------------- change detect / decode ----------------
  logic [2:0] r_last;
  logic       r_have;
  logic [2:0] r_color_idx;
  logic       w_event;
  logic [2:0] w_idx;
  logic [2:0] r_ref_idx;
  logic       w_inorder;

  assign w_event   = r_acc_stb && (!r_have || (r_acc_val != r_last));
  assign w_idx     = r_acc_val - 3'd1;
  assign w_inorder = (w_idx == (r_ref_idx + 3'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= '0;
      r_have      <= 1'b0;
      r_color_idx <= '0;
    end else if (w_event) begin
      r_last      <= r_acc_val;
      r_have      <= 1'b1;
      r_color_idx <= w_idx;
    end
  end

  // ---------------- sequence FSM ----------------
  state_t        r_state, w_state_nxt;
  logic [MW-1:0] r_match, w_match_nxt;
  logic [2:0]    w_ref_nxt;
  logic          r_locked, w_locked_nxt;
  logic          r_seq_err, w_seq_err_nxt;
  logic [7:0]    r_err_cnt, w_err_cnt_nxt;
  logic          w_stall_nxt;
  logic [7:0]    w_err_inc;

  assign w_err_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

`ifdef RGB_MON_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] r_idle;
  logic          r_stall;
  logic          w_tmo;

  // fires once on the cycle the idle count would reach the limit; the count then parks there
  assign w_tmo = !w_event && (r_state != S_HUNT) && (r_idle == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_idle <= '0;
    else if (w_event)
      r_idle <= '0;
    else if (r_idle != IW'(TIMEOUT_CYCLES))
      r_idle <= r_idle + IW'(1);
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_match_nxt   = r_match;
    w_ref_nxt     = r_ref_idx;
    w_locked_nxt  = r_locked;
    w_seq_err_nxt = 1'b0;
    w_err_cnt_nxt = r_err_cnt;
    w_stall_nxt   = 1'b0;
    if (w_event) begin
      w_ref_nxt = w_idx;
      case (r_state)
        S_HUNT: begin
          w_match_nxt = '0;
          w_state_nxt = S_CHECK;
        end
        S_CHECK: begin
          if (w_inorder) begin
            w_match_nxt = r_match + MW'(1);
            if (r_match == MW'(LOCK_COUNT - 1)) begin
              w_state_nxt  = S_LOCKED;
              w_locked_nxt = 1'b1;
            end
          end else begin
            w_seq_err_nxt = 1'b1;
            w_err_cnt_nxt = w_err_inc;
            w_match_nxt   = '0;
          end
        end
        S_LOCKED: begin
          if (!w_inorder) begin
            w_seq_err_nxt = 1'b1;
            w_err_cnt_nxt = w_err_inc;
            w_locked_nxt  = 1'b0;
            w_match_nxt   = '0;
            w_state_nxt   = S_CHECK;
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
`ifdef RGB_MON_TIMEOUT_EN
    else if (w_tmo) begin
      w_stall_nxt  = 1'b1;
      w_locked_nxt = 1'b0;
      w_state_nxt  = S_HUNT;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_HUNT;
      r_match   <= '0;
      r_ref_idx <= '0;
      r_locked  <= 1'b0;
      r_seq_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_match   <= w_match_nxt;
      r_ref_idx <= w_ref_nxt;
      r_locked  <= w_locked_nxt;
      r_seq_err <= w_seq_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

`ifdef RGB_MON_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stall <= 1'b0;
    else     r_stall <= w_stall_nxt;
  end
  assign bus.stall = r_stall;
`else
  // no idle counter in this build; the expression keeps the timeout parameter referenced
  localparam logic STALL_TIE = (TIMEOUT_CYCLES < 0);
  logic w_stall_unused;
  assign w_stall_unused = w_stall_nxt;
  assign bus.stall = STALL_TIE & w_stall_unused;
`endif

  assign bus.color_idx = r_color_idx;
  assign bus.idx_valid = r_have;
  assign bus.locked    = r_locked;
  assign bus.seq_error = r_seq_err;
  assign bus.err_count = r_err_cnt;

endmodule

// File: tb/tb_rgb_sequence_monitor.sv
// Scoreboard bench for rgb_sequence_monitor: stimulus pushes expected output tuples,
// a negedge monitor pops one per observed output change.
module tb_rgb_sequence_monitor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_sequence_monitor_if bus();

  rgb_sequence_monitor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;
  logic [14:0] exp_q[$];

  // tuple layout: {color_idx, idx_valid, locked, seq_error, err_count, stall}
  function automatic logic [14:0] mk(input logic [2:0] c, input logic v, input logic l,
                                     input logic s, input logic [7:0] e);
    return {c, v, l, s, e, 1'b0};
  endfunction

  function automatic logic [14:0] cur();
    return {bus.color_idx, bus.idx_valid, bus.locked, bus.seq_error, bus.err_count, bus.stall};
  endfunction

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp_v);
    n_tot++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endtask

  // monitor: every change of the output tuple outside reset consumes one expectation
  initial begin
    logic [14:0] last;
    logic [14:0] now_v;
    last = '0;
    forever begin
      @(negedge clk);
      now_v = cur();
      if (rst) last = '0;
      else if (now_v !== last) begin
        last = now_v;
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_change: got %h expected no change", now_v);
        end else begin
          chk("scoreboard", now_v, exp_q.pop_front());
        end
      end
    end
  end

  task automatic col(input logic [2:0] v, input int n);
    bus.BGR_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input logic [2:0] v, input logic [14:0] e);
    exp_q.push_back(e);
    col(v, 40);
  endtask

  initial begin
    bus.BGR_in = 3'b001;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", cur(), 15'd0);
    rst = 1'b0;

    // edge 0 is the first rising edge after release; outputs must move exactly after edge 19
    exp_q.push_back(mk(3'd0, 1, 0, 0, 8'd0));
    repeat (19) @(posedge clk);
    #1 chk("latency_edge18", cur(), 15'd0);
    @(posedge clk);
    #1 chk("latency_edge19", cur(), mk(3'd0, 1, 0, 0, 8'd0));
    @(negedge clk);
    col(3'b001, 20);

    step(3'b010, mk(3'd1, 1, 0, 0, 8'd0));
    step(3'b011, mk(3'd2, 1, 0, 0, 8'd0));
    step(3'b100, mk(3'd3, 1, 0, 0, 8'd0));
    step(3'b101, mk(3'd4, 1, 1, 0, 8'd0));
    chk("locked_after_5", cur(), mk(3'd4, 1, 1, 0, 8'd0));

    // wrap 6 -> 7 -> 0 while locked
    step(3'b110, mk(3'd5, 1, 1, 0, 8'd0));
    step(3'b111, mk(3'd6, 1, 1, 0, 8'd0));
    step(3'b000, mk(3'd7, 1, 1, 0, 8'd0));
    step(3'b001, mk(3'd0, 1, 1, 0, 8'd0));
    chk("wrap_locked", cur(), mk(3'd0, 1, 1, 0, 8'd0));

    // out-of-order jump while locked, then relock with four ordered changes
    step(3'b010, mk(3'd1, 1, 1, 0, 8'd0));
    exp_q.push_back(mk(3'd4, 1, 0, 1, 8'd1));
    step(3'b101, mk(3'd4, 1, 0, 0, 8'd1));
    chk("jump_error", cur(), mk(3'd4, 1, 0, 0, 8'd1));
    step(3'b110, mk(3'd5, 1, 0, 0, 8'd1));
    step(3'b111, mk(3'd6, 1, 0, 0, 8'd1));
    step(3'b000, mk(3'd7, 1, 0, 0, 8'd1));
    step(3'b001, mk(3'd0, 1, 1, 0, 8'd1));
    chk("relock", cur(), mk(3'd0, 1, 1, 0, 8'd1));
    step(3'b010, mk(3'd1, 1, 1, 0, 8'd1));
    step(3'b011, mk(3'd2, 1, 1, 0, 8'd1));

    // short glitch must be filtered out entirely
    col(3'b110, 10);
    col(3'b011, 40);
    chk("glitch_filtered", cur(), mk(3'd2, 1, 1, 0, 8'd1));

    // mid-operation reset clears outputs at once; HUNT start from a non-zero index
    rst = 1'b1;
    #1 chk("async_reset", cur(), 15'd0);
    bus.BGR_in = 3'b101;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(mk(3'd4, 1, 0, 0, 8'd0));
    col(3'b101, 40);
    step(3'b110, mk(3'd5, 1, 0, 0, 8'd0));
    // out of order while still in CHECK
    exp_q.push_back(mk(3'd0, 1, 0, 1, 8'd1));
    step(3'b001, mk(3'd0, 1, 0, 0, 8'd1));
    chk("check_error", cur(), mk(3'd0, 1, 0, 0, 8'd1));

    repeat (10) @(negedge clk);
    n_tot++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
